// File: rtl/csc_rgb2ycbcr_pipe.sv
// rtl/csc_rgb2ycbcr_pipe.sv - pipelined RGB to YCbCr converter, BT.601/BT.709/bypass, 4-cycle latency
module csc_rgb2ycbcr_pipe #(
  parameter int DW  = 8,
  parameter int LAT = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          vs_in,
  input  logic          hs_in,
  input  logic          de_in,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  input  logic [1:0]    mode_sel,
  output logic          vs_out,
  output logic          hs_out,
  output logic          de_out,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] cb_out,
  output logic [DW-1:0] cr_out,
  output logic [1:0]    mode_active
);

  localparam int PW = DW + 10;
  localparam int SW = DW + 12;

  localparam logic signed [SW-1:0] RND   = SW'(128);
  localparam logic signed [SW-1:0] Y_OFF = SW'(16 << (DW - 8));
  localparam logic signed [SW-1:0] C_OFF = SW'(128 << (DW - 8));
  localparam logic signed [SW-1:0] MAXV  = SW'((1 << DW) - 1);

  logic                 vs_prev;
  logic [1:0]           mode_now;
  logic [LAT-1:0]       vs_d, hs_d, de_d;

  logic [DW-1:0]        raw1 [3];
  logic [DW-1:0]        raw2 [3];
  logic [DW-1:0]        raw3 [3];
  logic [1:0]           mode1;
  logic                 byp2, byp3;

  logic signed [8:0]    cf   [9];
  logic signed [PW-1:0] prod [9];
  logic signed [PW-1:0] p2   [9];
  logic signed [SW-1:0] s3   [3];
  logic signed [SW-1:0] shv  [3];
  logic [DW-1:0]        clp  [3];

  // A pixel arriving with the vs rising edge already belongs to the new frame's mode
  assign mode_now = (vs_in && !vs_prev) ? mode_sel : mode_active;

  // Frame mode latch on vs rising edge
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vs_prev     <= 1'b0;
      mode_active <= 2'b00;
    end else begin
      vs_prev     <= vs_in;
      mode_active <= mode_now;
    end
  end

  // Sync delay lines, same depth as the datapath
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vs_d <= '0;
      hs_d <= '0;
      de_d <= '0;
    end else begin
      vs_d <= {vs_d[LAT-2:0], vs_in};
      hs_d <= {hs_d[LAT-2:0], hs_in};
      de_d <= {de_d[LAT-2:0], de_in};
    end
  end

  assign vs_out = vs_d[LAT-1];
  assign hs_out = hs_d[LAT-1];
  assign de_out = de_d[LAT-1];

  // S1: register pixel components and the mode they are converted with
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 3; i++) raw1[i] <= '0;
      mode1 <= 2'b00;
    end else begin
      raw1[0] <= r_in;
      raw1[1] <= g_in;
      raw1[2] <= b_in;
      mode1   <= mode_now;
    end
  end

  // Coefficient table, rows Y/Cb/Cr, columns R/G/B, scaled by 256
  always_comb begin
    cf[0] =  9'sd66;  cf[1] =  9'sd129; cf[2] =  9'sd25;
    cf[3] = -9'sd38;  cf[4] = -9'sd74;  cf[5] =  9'sd112;
    cf[6] =  9'sd112; cf[7] = -9'sd94;  cf[8] = -9'sd18;
    if (mode1 == 2'b01) begin
      cf[0] =  9'sd47;  cf[1] =  9'sd157; cf[2] =  9'sd16;
      cf[3] = -9'sd26;  cf[4] = -9'sd86;  cf[5] =  9'sd112;
      cf[6] =  9'sd112; cf[7] = -9'sd102; cf[8] = -9'sd10;
    end
  end

  // Nine signed products: component zero-extended, coefficient sign-extended
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      for (int c = 0; c < 3; c++) begin
        prod[ch*3+c] = PW'($signed({1'b0, raw1[c]})) * PW'(cf[ch*3+c]);
      end
    end
  end

  // S2: register products, carry raw pixel for bypass
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 9; i++) p2[i] <= '0;
      for (int i = 0; i < 3; i++) raw2[i] <= '0;
      byp2 <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) p2[i] <= prod[i];
      for (int i = 0; i < 3; i++) raw2[i] <= raw1[i];
      byp2 <= mode1[1];
    end
  end

  // S3: per-channel sum with rounding constant
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 3; i++) s3[i] <= '0;
      for (int i = 0; i < 3; i++) raw3[i] <= '0;
      byp3 <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        s3[ch] <= SW'(p2[ch*3]) + SW'(p2[ch*3+1]) + SW'(p2[ch*3+2]) + RND;
      end
      for (int i = 0; i < 3; i++) raw3[i] <= raw2[i];
      byp3 <= byp2;
    end
  end

  // Floor shift, offset and clamp into the unsigned output range
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      shv[ch] = (s3[ch] >>> 8) + ((ch == 0) ? Y_OFF : C_OFF);
      clp[ch] = shv[ch][DW-1:0];
      if (shv[ch] < 0) begin
        clp[ch] = '0;
      end else if (shv[ch] > MAXV) begin
        clp[ch] = MAXV[DW-1:0];
      end
    end
  end

  // S4: output register with blanking while the aligned de is low
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      y_out  <= '0;
      cb_out <= '0;
      cr_out <= '0;
    end else if (!de_d[LAT-2]) begin
      y_out  <= '0;
      cb_out <= '0;
      cr_out <= '0;
    end else if (byp3) begin
      y_out  <= raw3[0];
      cb_out <= raw3[1];
      cr_out <= raw3[2];
    end else begin
      y_out  <= clp[0];
      cb_out <= clp[1];
      cr_out <= clp[2];
    end
  end

endmodule

// File: tb/tb_csc_rgb2ycbcr_pipe.sv
// tb/tb_csc_rgb2ycbcr_pipe.sv - self-checking bench for csc_rgb2ycbcr_pipe at DW=8 and DW=10
module tb_csc_rgb2ycbcr_pipe;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        vs_in, hs_in, de_in;
  logic [1:0]  mode_sel;
  logic [7:0]  r8, g8, b8;
  logic [9:0]  r10, g10, b10;

  logic        vs8, hs8, de8, vs10, hs10, de10;
  logic [7:0]  y8, cb8, cr8;
  logic [9:0]  y10, cb10, cr10;
  logic [1:0]  mode8, mode10;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic vs, hs, de;
    int   y8, cb8, cr8, y10, cb10, cr10;
  } exp_t;

  exp_t q[$];
  int   m_mode = 0;
  logic m_prev = 1'b0;

  always #5 clk = ~clk;

  csc_rgb2ycbcr_pipe #(.DW(8), .LAT(4)) dut8 (
    .clk(clk), .rst_b(rst_b), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .r_in(r8), .g_in(g8), .b_in(b8), .mode_sel(mode_sel),
    .vs_out(vs8), .hs_out(hs8), .de_out(de8),
    .y_out(y8), .cb_out(cb8), .cr_out(cr8), .mode_active(mode8)
  );

  csc_rgb2ycbcr_pipe #(.DW(10), .LAT(4)) dut10 (
    .clk(clk), .rst_b(rst_b), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .r_in(r10), .g_in(g10), .b_in(b10), .mode_sel(mode_sel),
    .vs_out(vs10), .hs_out(hs10), .de_out(de10),
    .y_out(y10), .cb_out(cb10), .cr_out(cr10), .mode_active(mode10)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  // Reference conversion straight from the colour-matrix definition
  function automatic void conv(input int dw, input int md, input logic de,
                               input int r, input int g, input int b,
                               output int y, output int cb, output int cr);
    int k[9];
    int sc, mx;
    sc = 1 << (dw - 8);
    mx = (1 << dw) - 1;
    if (!de) begin
      y = 0; cb = 0; cr = 0;
    end else if (md >= 2) begin
      y = r; cb = g; cr = b;
    end else begin
      if (md == 1) k = '{47, 157, 16, -26, -86, 112, 112, -102, -10};
      else         k = '{66, 129, 25, -38, -74, 112, 112, -94, -18};
      y  = clampi(((k[0]*r + k[1]*g + k[2]*b + 128) >>> 8) + 16*sc,  mx);
      cb = clampi(((k[3]*r + k[4]*g + k[5]*b + 128) >>> 8) + 128*sc, mx);
      cr = clampi(((k[6]*r + k[7]*g + k[8]*b + 128) >>> 8) + 128*sc, mx);
    end
  endfunction

  task automatic step(input logic v, input logic h, input logic d, input logic [1:0] ms,
                      input int r, input int g, input int b,
                      input int ra, input int ga, input int ba);
    exp_t e;
    vs_in = v; hs_in = h; de_in = d; mode_sel = ms;
    r8 = 8'(r); g8 = 8'(g); b8 = 8'(b);
    r10 = 10'(ra); g10 = 10'(ga); b10 = 10'(ba);
    if (v && !m_prev) m_mode = int'(ms);
    m_prev = v;
    e.vs = v; e.hs = h; e.de = d;
    conv(8,  m_mode, d, r,  g,  b,  e.y8,  e.cb8,  e.cr8);
    conv(10, m_mode, d, ra, ga, ba, e.y10, e.cb10, e.cr10);
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 4) e = q.pop_front();
    else e = '{default: 0};
    check("dat8", {vs8, hs8, de8, y8, cb8, cr8},
          {e.vs, e.hs, e.de, 8'(e.y8), 8'(e.cb8), 8'(e.cr8)});
    check("dat10", {vs10, hs10, de10, y10, cb10, cr10},
          {e.vs, e.hs, e.de, 10'(e.y10), 10'(e.cb10), 10'(e.cr10)});
    check("mode", {mode8, mode10}, {2'(m_mode), 2'(m_mode)});
  endtask

  task automatic idle(input logic [1:0] ms);
    step(1'b0, 1'b0, 1'b0, ms, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic v;
    rst_b = 1'b0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; mode_sel = 2'b00;
    r8 = '0; g8 = '0; b8 = '0; r10 = '0; g10 = '0; b10 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out8",  {vs8, hs8, de8, y8, cb8, cr8, mode8}, 64'd0);
    check("rst_out10", {vs10, hs10, de10, y10, cb10, cr10, mode10}, 64'd0);
    rst_b = 1'b1;

    // BT.601 white, black, red
    step(0, 0, 1, 2'b00, 255, 255, 255, 1023, 1023, 1023);
    step(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2'b00, 255, 0, 0, 1023, 0, 0);
    idle(2'b00);
    check("w601_8",  {y8, cb8, cr8},    {8'd235, 8'd128, 8'd128});
    check("w601_10", {y10, cb10, cr10}, {10'd943, 10'd512, 10'd512});
    idle(2'b00);
    check("k601_8",  {y8, cb8, cr8},    {8'd16, 8'd128, 8'd128});
    check("k601_10", {y10, cb10, cr10}, {10'd64, 10'd512, 10'd512});
    idle(2'b00);
    check("r601_8",  {y8, cb8, cr8},    {8'd82, 8'd90, 8'd240});

    // Switch to BT.709 at a vs rising edge
    step(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    check("mode709", mode8, 2'b01);
    step(0, 0, 1, 2'b01, 255, 0, 0, 1023, 0, 0);
    step(0, 0, 1, 2'b01, 255, 255, 255, 1023, 1023, 1023);
    idle(2'b01);
    idle(2'b01);
    check("r709_8", {y8, cb8, cr8}, {8'd63, 8'd102, 8'd240});
    idle(2'b01);
    check("w709_8", {y8, cb8, cr8}, {8'd235, 8'd128, 8'd128});

    // Mid-frame request for bypass is ignored until the next vs edge
    step(0, 0, 1, 2'b10, 255, 0, 0, 1023, 0, 0);
    idle(2'b10);
    idle(2'b10);
    idle(2'b10);
    check("midfr_8", {y8, cb8, cr8, mode8}, {8'd63, 8'd102, 8'd240, 2'b01});
    step(1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2'b10, 12, 34, 56, 12, 34, 56);
    idle(2'b10);
    idle(2'b10);
    idle(2'b10);
    check("byp_8", {y8, cb8, cr8, mode8}, {8'd12, 8'd34, 8'd56, 2'b10});

    // Random sync patterns, modes and pixels
    v = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 11) == 0) v = ~v;
      step(v, 1'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom),
           int'($urandom_range(0, 255)),  int'($urandom_range(0, 255)),  int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end

    // Reset mid-frame: immediate flush, clean restart
    rst_b = 1'b0;
    #1;
    check("mrst_out8",  {vs8, hs8, de8, y8, cb8, cr8, mode8}, 64'd0);
    check("mrst_out10", {vs10, hs10, de10, y10, cb10, cr10, mode10}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mrst_hold", {vs8, de8, y8, mode8, vs10, y10}, 64'd0);
    rst_b = 1'b1;
    q.delete();
    m_mode = 0;
    m_prev = 1'b0;
    step(0, 0, 1, 2'b00, 255, 255, 255, 1023, 1023, 1023);
    idle(2'b00);
    idle(2'b00);
    idle(2'b00);
    check("rst_first", {de8, y8, cb8, cr8}, {1'b1, 8'd235, 8'd128, 8'd128});

    v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) v = ~v;
      step(v, 1'($urandom), 1'($urandom), 2'($urandom),
           int'($urandom_range(0, 255)),  int'($urandom_range(0, 255)),  int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
